// File: rtl/ra_rdchk_sdr.sv
// ra_rdchk_sdr: read-side sweep checker for the 2R1W 64x72 SDR array.
// Both read ports walk an inclusive address range two words per cycle and
// every returned word is compared against the byte pattern seed ^ address,
// replicated nine times and optionally complemented. The checker reports
// mismatch count, first failing address and pass/fail.
// Optional build macro RA_RDCHK_STOPONFAIL_EN: the first mismatch stops
// issuing and lets the in-flight reads drain before completing.

module ra_rdchk_sdr #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  seed,
    input  logic        invert,
    input  logic [5:0]  adr_lo,
    input  logic [5:0]  adr_hi,
    output logic        rd_enb_0,
    output logic        rd_enb_1,
    output logic [5:0]  rd_adr_0,
    output logic [5:0]  rd_adr_1,
    input  logic [71:0] rd_dat_0,
    input  logic [71:0] rd_dat_1,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [6:0]  err_cnt,
    output logic        fail_vld,
    output logic [5:0]  fail_adr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    state_t     state_q, state_d;
    logic [6:0] ptr_q, ptr_d;
    logic [7:0] seed_q, seed_d;
    logic       invert_q, invert_d;
    logic [5:0] hi_q, hi_d;
    logic [1:0] drain_q, drain_d;
    logic [6:0] errCnt_q, errCnt_d;
    logic       pass_q, pass_d;
    logic       failVld_q, failVld_d;
    logic [5:0] failAdr_q, failAdr_d;

    logic [RD_LAT-1:0]      pEnb0_q, pEnb0_d;
    logic [RD_LAT-1:0]      pEnb1_q, pEnb1_d;
    logic [RD_LAT-1:0][5:0] pAdr0_q, pAdr0_d;
    logic [RD_LAT-1:0][5:0] pAdr1_q, pAdr1_d;

    logic [6:0] ptrPlus1;
    logic [6:0] ptrPlus2;
    logic       tapEnb0, tapEnb1;
    logic [5:0] tapAdr0, tapAdr1;
    logic       mis0, mis1;
    logic [7:0] errSum;
    logic [6:0] errSat;

    // Pattern the array should hold at address a for the captured seed/invert.
    function automatic logic [71:0] expWord(input logic [5:0] a,
                                            input logic [7:0] s,
                                            input logic       inv);
        logic [7:0]  e;
        logic [71:0] w;
        e = s ^ {2'b00, a};
        w = {9{e}};
        expWord = inv ? ~w : w;
    endfunction

    assign ptrPlus1 = ptr_q + 7'd1;
    assign ptrPlus2 = ptr_q + 7'd2;

    assign tapEnb0 = pEnb0_q[RD_LAT-1];
    assign tapEnb1 = pEnb1_q[RD_LAT-1];
    assign tapAdr0 = pAdr0_q[RD_LAT-1];
    assign tapAdr1 = pAdr1_q[RD_LAT-1];

    assign mis0 = tapEnb0 && (rd_dat_0 != expWord(tapAdr0, seed_q, invert_q));
    assign mis1 = tapEnb1 && (rd_dat_1 != expWord(tapAdr1, seed_q, invert_q));

    assign errSum = {1'b0, errCnt_q} + {7'b0, mis0} + {7'b0, mis1};
    assign errSat = (errSum > 8'd127) ? 7'd127 : errSum[6:0];

    // Read port drive: port 1 takes the odd partner only while it is in range.
    always_comb begin
        rd_enb_0 = 1'b0;
        rd_enb_1 = 1'b0;
        rd_adr_0 = 6'd0;
        rd_adr_1 = 6'd0;
        if (state_q == ISSUE) begin
            rd_enb_0 = 1'b1;
            rd_adr_0 = ptr_q[5:0];
            if (ptrPlus1 <= {1'b0, hi_q}) begin
                rd_enb_1 = 1'b1;
                rd_adr_1 = ptrPlus1[5:0];
            end
        end
    end

    // Next-state: compare pipeline shift, result accumulation and FSM flow.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        seed_d    = seed_q;
        invert_d  = invert_q;
        hi_d      = hi_q;
        drain_d   = drain_q;
        errCnt_d  = errCnt_q;
        pass_d    = pass_q;
        failVld_d = failVld_q;
        failAdr_d = failAdr_q;

        pEnb0_d    = pEnb0_q << 1;
        pEnb1_d    = pEnb1_q << 1;
        pAdr0_d    = pAdr0_q << 6;
        pAdr1_d    = pAdr1_q << 6;
        pEnb0_d[0] = rd_enb_0;
        pEnb1_d[0] = rd_enb_1;
        pAdr0_d[0] = rd_adr_0;
        pAdr1_d[0] = rd_adr_1;

        if (mis0 || mis1) begin
            errCnt_d = errSat;
            if (!failVld_q) begin
                failVld_d = 1'b1;
                failAdr_d = mis0 ? tapAdr0 : tapAdr1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    seed_d    = seed;
                    invert_d  = invert;
                    hi_d      = adr_hi;
                    errCnt_d  = 7'd0;
                    failVld_d = 1'b0;
                    if (adr_lo <= adr_hi) begin
                        state_d = ISSUE;
                        ptr_d   = {1'b0, adr_lo};
                        pass_d  = 1'b0;
                    end else begin
                        state_d = DONE;
                        pass_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                ptr_d = ptrPlus2;
`ifdef RA_RDCHK_STOPONFAIL_EN
                if ((ptrPlus2 > {1'b0, hi_q}) || mis0 || mis1) begin
`else
                if (ptrPlus2 > {1'b0, hi_q}) begin
`endif
                    state_d = DRAIN;
                    drain_d = DRAIN_LAST;
                end
            end
            DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = DONE;
                    pass_d  = (errCnt_d == 7'd0);
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= 7'd0;
            seed_q    <= 8'd0;
            invert_q  <= 1'b0;
            hi_q      <= 6'd0;
            drain_q   <= 2'd0;
            errCnt_q  <= 7'd0;
            pass_q    <= 1'b0;
            failVld_q <= 1'b0;
            failAdr_q <= 6'd0;
            pEnb0_q   <= '0;
            pEnb1_q   <= '0;
            pAdr0_q   <= '0;
            pAdr1_q   <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            seed_q    <= seed_d;
            invert_q  <= invert_d;
            hi_q      <= hi_d;
            drain_q   <= drain_d;
            errCnt_q  <= errCnt_d;
            pass_q    <= pass_d;
            failVld_q <= failVld_d;
            failAdr_q <= failAdr_d;
            pEnb0_q   <= pEnb0_d;
            pEnb1_q   <= pEnb1_d;
            pAdr0_q   <= pAdr0_d;
            pAdr1_q   <= pAdr1_d;
        end
    end

    assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign err_cnt  = errCnt_q;
    assign fail_vld = failVld_q;
    assign fail_adr = failAdr_q;

endmodule

// File: tb/tb_ra_rdchk_sdr.sv
// tb_ra_rdchk_sdr: directed bench for ra_rdchk_sdr. Two instances share the
// configuration inputs: one with RD_LAT=1 over array image mem1, one with
// RD_LAT=3 over mem3 (which holds complemented patterns).

module tb_ra_rdchk_sdr;

`ifdef RA_RDCHK_STOPONFAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start1, start3;
    logic [7:0] seed;
    logic       invert;
    logic [5:0] adrLo, adrHi;

    logic        enb0L1, enb1L1, busyL1, doneL1, passL1, fvldL1;
    logic [5:0]  adr0L1, adr1L1, fadrL1;
    logic [6:0]  errL1;
    logic [71:0] dat0L1, dat1L1;
    logic        enb0L3, enb1L3, busyL3, doneL3, passL3, fvldL3;
    logic [5:0]  adr0L3, adr1L3, fadrL3;
    logic [6:0]  errL3;
    logic [71:0] dat0L3, dat1L3;

    logic [71:0] mem1 [64];
    logic [71:0] mem3 [64];
    logic [5:0]  q1a0, q1a1;
    logic [5:0]  q3a0 [3];
    logic [5:0]  q3a1 [3];

    int totalCnt = 0;
    int passCnt  = 0;

    ra_rdchk_sdr #(.RD_LAT(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .seed(seed), .invert(invert),
        .adr_lo(adrLo), .adr_hi(adrHi),
        .rd_enb_0(enb0L1), .rd_enb_1(enb1L1), .rd_adr_0(adr0L1), .rd_adr_1(adr1L1),
        .rd_dat_0(dat0L1), .rd_dat_1(dat1L1),
        .busy(busyL1), .done(doneL1), .pass(passL1), .err_cnt(errL1),
        .fail_vld(fvldL1), .fail_adr(fadrL1)
    );

    ra_rdchk_sdr #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .seed(seed), .invert(invert),
        .adr_lo(adrLo), .adr_hi(adrHi),
        .rd_enb_0(enb0L3), .rd_enb_1(enb1L3), .rd_adr_0(adr0L3), .rd_adr_1(adr1L3),
        .rd_dat_0(dat0L3), .rd_dat_1(dat1L3),
        .busy(busyL3), .done(doneL3), .pass(passL3), .err_cnt(errL3),
        .fail_vld(fvldL3), .fail_adr(fadrL3)
    );

    // Array read models: address registered at the issue edge, data valid RD_LAT cycles later.
    always @(posedge clk) begin
        q1a0    <= adr0L1;
        q1a1    <= adr1L1;
        q3a0[0] <= adr0L3;
        q3a0[1] <= q3a0[0];
        q3a0[2] <= q3a0[1];
        q3a1[0] <= adr1L3;
        q3a1[1] <= q3a1[0];
        q3a1[2] <= q3a1[1];
    end

    assign dat0L1 = mem1[q1a0];
    assign dat1L1 = mem1[q1a1];
    assign dat0L3 = mem3[q3a0[2]];
    assign dat1L3 = mem3[q3a1[2]];

    typedef struct {
        logic       enb0, enb1;
        logic [5:0] adr0, adr1;
        logic       busy, done, pass;
        logic [6:0] err;
        logic       fvld;
        logic [5:0] fadr;
    } obs_t;

    typedef struct {
        string      name;
        int         sel;
        bit         fault;
        logic [5:0] lo, hi;
        logic [7:0] seed;
        logic       inv;
        int         expIssue;
        int         expDone;
        int         expErr;
        logic       expVld;
        logic [5:0] expFadr;
        logic       expPass;
        int         pokeAt;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [71:0] pat(input logic [7:0] s, input logic [5:0] a,
                                        input logic inv);
        logic [7:0] e;
        e   = s ^ {2'b00, a};
        pat = inv ? ~{9{e}} : {9{e}};
    endfunction

    function automatic obs_t sample(input int sel);
        obs_t o;
        if (sel == 1) begin
            o = '{enb0L1, enb1L1, adr0L1, adr1L1, busyL1, doneL1, passL1, errL1, fvldL1, fadrL1};
        end else begin
            o = '{enb0L3, enb1L3, adr0L3, adr1L3, busyL3, doneL3, passL3, errL3, fvldL3, fadrL3};
        end
        return o;
    endfunction

    function automatic vec_t mkVec(input string n, input int sel, input bit fault,
                                   input logic [5:0] lo, input logic [5:0] hi,
                                   input logic [7:0] sd, input logic inv,
                                   input int ki, input int kd, input int ke,
                                   input logic vld, input logic [5:0] fa,
                                   input logic ps, input int poke);
        vec_t v;
        v = '{n, sel, fault, lo, hi, sd, inv, ki, kd, ke, vld, fa, ps, poke};
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        totalCnt++;
        if (act === exp) begin
            passCnt++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive configuration and pulse start on one instance; returns inside cycle T+1.
    task automatic applyStimulus(input int sel, input logic [5:0] lo, input logic [5:0] hi,
                                 input logic [7:0] sd, input logic inv);
        @(negedge clk);
        adrLo  = lo;
        adrHi  = hi;
        seed   = sd;
        invert = inv;
        if (sel == 1) start1 = 1'b1;
        else          start3 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic runSweep(input vec_t v);
        obs_t o;
        int   p;
        int   doneAt;
        int   doneCnt;
        int   adrErrs;
        int   busyErrs;
        logic expEnb1;
        logic [6:0] errAt;
        logic passAt, vldAt;
        logic [5:0] fadrAt;
        p        = v.lo;
        doneAt   = -1;
        doneCnt  = 0;
        adrErrs  = 0;
        busyErrs = 0;
        errAt    = '0;
        passAt   = 1'b0;
        vldAt    = 1'b0;
        fadrAt   = '0;
        if (v.fault) begin
            mem1[12] = pat(8'hA5, 6'd12, 1'b0) ^ (72'd1 << 17);
            mem1[13] = pat(8'hA5, 6'd13, 1'b0) ^ 72'd1;
        end
        applyStimulus(v.sel, v.lo, v.hi, v.seed, v.inv);
        for (int c = 1; c <= v.expDone + 2; c++) begin
            o = sample(v.sel);
            if (c <= v.expIssue) begin
                expEnb1 = (p + 1 <= int'(v.hi));
                if (o.enb0 !== 1'b1 || o.adr0 !== 6'(p) || o.enb1 !== expEnb1 ||
                    o.adr1 !== (expEnb1 ? 6'(p + 1) : 6'd0)) adrErrs++;
                p += 2;
            end else if (o.enb0 !== 1'b0 || o.enb1 !== 1'b0) begin
                adrErrs++;
            end
            if (o.busy !== ((v.expIssue > 0) && (c < v.expDone))) busyErrs++;
            if (o.done === 1'b1) begin
                doneCnt++;
                if (doneAt < 0) doneAt = c;
            end
            if (c == v.expDone) begin
                errAt  = o.err;
                passAt = o.pass;
                vldAt  = o.fvld;
                fadrAt = o.fadr;
            end
            if (v.pokeAt > 0 && c == v.pokeAt) begin
                adrLo  = 6'd40;
                adrHi  = 6'd41;
                start1 = 1'b1;
            end
            if (v.pokeAt > 0 && c == v.pokeAt + 1) start1 = 1'b0;
            @(negedge clk);
        end
        checkOutput({v.name, ".doneCycle"}, doneAt, v.expDone);
        checkOutput({v.name, ".donePulses"}, doneCnt, 1);
        checkOutput({v.name, ".readSeqErrs"}, adrErrs, 0);
        checkOutput({v.name, ".busyErrs"}, busyErrs, 0);
        checkOutput({v.name, ".errCnt"}, errAt, v.expErr);
        checkOutput({v.name, ".pass"}, passAt, v.expPass);
        checkOutput({v.name, ".failVld"}, vldAt, v.expVld);
        if (v.expVld) checkOutput({v.name, ".failAdr"}, fadrAt, v.expFadr);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        obs_t o;
        int   doneSeen;
        int   busySeen;
        vec_t lone;

        vecs[0]  = mkVec("full_clean",  1, 0, 6'd0,  6'd63, 8'hA5, 0, 32, 34, 0, 0, 6'd0,  1, 0);
        vecs[1]  = mkVec("odd_range",   1, 0, 6'd5,  6'd9,  8'hA5, 0, 3,  5,  0, 0, 6'd0,  1, 0);
        vecs[2]  = mkVec("empty",       1, 0, 6'd10, 6'd9,  8'hA5, 0, 0,  1,  0, 0, 6'd0,  1, 0);
        vecs[3]  = mkVec("fault_pair",  1, 1, 6'd12, 6'd13, 8'hA5, 0, 1,  3,  2, 1, 6'd12, 0, 0);
        vecs[4]  = mkVec("fault_port0", 1, 1, 6'd13, 6'd14, 8'hA5, 0, 1,  3,  1, 1, 6'd13, 0, 0);
        vecs[5]  = mkVec("fault_port1", 1, 1, 6'd11, 6'd13, 8'hA5, 0, 2,  4,  2, 1, 6'd12, 0, 0);
        vecs[6]  = mkVec("wrong_seed",  1, 1, 6'd20, 6'd21, 8'h5A, 0, 1,  3,  2, 1, 6'd20, 0, 0);
        vecs[7]  = mkVec("full_fault",  1, 1, 6'd0,  6'd63, 8'hA5, 0, STOP ? 8 : 32,
                         STOP ? 10 : 34, 2, 1, 6'd12, 0, 0);
        vecs[8]  = mkVec("busy_start",  1, 1, 6'd0,  6'd63, 8'hA5, 0, STOP ? 8 : 32,
                         STOP ? 10 : 34, 2, 1, 6'd12, 0, 5);
        vecs[9]  = mkVec("lat3_invert", 3, 0, 6'd0,  6'd3,  8'h3C, 1, 2,  6,  0, 0, 6'd0,  1, 0);
        vecs[10] = mkVec("lat3_noinv",  3, 0, 6'd0,  6'd3,  8'h3C, 0, 2,  6,  4, 1, 6'd0,  0, 0);

        for (int a = 0; a < 64; a++) begin
            mem1[a] = pat(8'hA5, 6'(a), 1'b0);
            mem3[a] = pat(8'h3C, 6'(a), 1'b1);
        end

        reset  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
        seed   = 8'h00;
        invert = 1'b0;
        adrLo  = 6'd0;
        adrHi  = 6'd0;
        repeat (3) @(negedge clk);

        o = sample(1);
        checkOutput("rst.enb0", o.enb0, 0);
        checkOutput("rst.enb1", o.enb1, 0);
        checkOutput("rst.adr0", o.adr0, 0);
        checkOutput("rst.busy", o.busy, 0);
        checkOutput("rst.done", o.done, 0);
        checkOutput("rst.pass", o.pass, 0);
        checkOutput("rst.err",  o.err,  0);
        checkOutput("rst.fvld", o.fvld, 0);
        o = sample(3);
        checkOutput("rst3.busy", o.busy, 0);
        checkOutput("rst3.done", o.done, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            runSweep(vecs[i]);
        end

        // Reset asserted during the 4th issue cycle of a full sweep.
        applyStimulus(1, 6'd0, 6'd63, 8'hA5, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            o = sample(1);
            if (c == 4) checkOutput("midrst.issuing", o.enb0, 1);
            if (c == 4) reset = 1'b0;
            @(negedge clk);
        end
        o = sample(1);
        checkOutput("midrst.enb0", o.enb0, 0);
        checkOutput("midrst.enb1", o.enb1, 0);
        checkOutput("midrst.adr0", o.adr0, 0);
        checkOutput("midrst.adr1", o.adr1, 0);
        checkOutput("midrst.busy", o.busy, 0);
        checkOutput("midrst.done", o.done, 0);
        checkOutput("midrst.pass", o.pass, 0);
        checkOutput("midrst.err",  o.err,  0);
        checkOutput("midrst.fvld", o.fvld, 0);
        checkOutput("midrst.fadr", o.fadr, 0);
        reset    = 1'b1;
        doneSeen = 0;
        busySeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            o = sample(1);
            if (o.done === 1'b1) doneSeen++;
            if (o.busy === 1'b1) busySeen++;
        end
        checkOutput("midrst.noDone", doneSeen, 0);
        checkOutput("midrst.noBusy", busySeen, 0);

        lone = mkVec("top_single", 1, 0, 6'd63, 6'd63, 8'hA5, 0, 1, 3, 0, 0, 6'd0, 1, 0);
        runSweep(lone);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
